// File: rtl/soc_system_key_in_pio.sv
// rtl/soc_system_key_in_pio.sv - Avalon-MM input PIO with synchronizer, W1C edge capture and level irq.
// Optional per-bit debounce filter is compiled in with KEY_IN_PIO_DEBOUNCE_EN.
module soc_system_key_in_pio #(
  parameter int WIDTH           = 4,
  parameter int CAPTURE_FALLING = 1,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] edges;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] wr_bits;
  logic [WIDTH-1:0] clr_bits;
  logic             wr_en;
  logic [31:0]      rd_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= in_port;
      s2 <= s1;
    end
  end

`ifdef KEY_IN_PIO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // A bit only follows s2 after it has disagreed with filt for a full window.
  for (genvar i = 0; i < WIDTH; i++) begin : g_debounce
    logic [CNT_W-1:0] cnt;
    logic             filt_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt    <= '0;
        filt_q <= 1'b0;
      end else if (s2[i] == filt_q) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt    <= '0;
        filt_q <= s2[i];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign filt[i] = filt_q;
  end
`else
  assign filt = s2;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev <= '0;
    end else begin
      prev <= filt;
    end
  end

  assign edges = (CAPTURE_FALLING != 0) ? (~filt & prev) : (filt & ~prev);

  assign wr_en    = chipselect && !write_n;
  assign wr_bits  = writedata[WIDTH-1:0];
  assign clr_bits = (wr_en && address == 2'd3) ? wr_bits : '0;

  // Set is OR-ed in after the clear so a simultaneous edge keeps the bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_capture <= '0;
    end else begin
      edge_capture <= (edge_capture & ~clr_bits) | edges;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask <= '0;
    end else if (wr_en && address == 2'd2) begin
      irq_mask <= wr_bits;
    end
  end

  always_comb begin
    rd_next = '0;
    case (address)
      2'd0:    rd_next[WIDTH-1:0] = filt;
      2'd2:    rd_next[WIDTH-1:0] = irq_mask;
      2'd3:    rd_next[WIDTH-1:0] = edge_capture;
      default: rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_next;
    end
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_soc_system_key_in_pio.sv
// tb/tb_soc_system_key_in_pio.sv - self-checking bench for soc_system_key_in_pio (WIDTH=4, falling capture).
// Directed vector table, reset corners and a randomized run against a delay-line reference model.
module tb_soc_system_key_in_pio;

  localparam int WIDTH = 4;
  localparam int DB    = 8;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [1:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [WIDTH-1:0] in_port;
  logic [31:0]      readdata;
  logic             irq;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  soc_system_key_in_pio #(
    .WIDTH(WIDTH),
    .CAPTURE_FALLING(1),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .in_port(in_port),
    .readdata(readdata),
    .irq(irq)
  );

  typedef struct {
    logic [1:0]       addr;
    logic             cs;
    logic             wn;
    logic [31:0]      wd;
    logic [WIDTH-1:0] inp;
    logic [31:0]      exp_rd;
    logic             exp_irq;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic add(input logic [1:0] a, input logic c, input logic w, input logic [31:0] d,
                     input logic [WIDTH-1:0] i, input logic [31:0] r, input logic q);
    vec_t v;
    v.addr = a; v.cs = c; v.wn = w; v.wd = d; v.inp = i; v.exp_rd = r; v.exp_irq = q;
    vecs.push_back(v);
  endtask

  // Drive at a negedge, step through one rising edge, return at the next negedge.
  task automatic step(input logic [1:0] a, input logic c, input logic w, input logic [31:0] d,
                      input logic [WIDTH-1:0] i);
    address = a; chipselect = c; write_n = w; writedata = d; in_port = i;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [WIDTH-1:0] i);
    @(negedge clk);
    reset_n = 1'b0;
    address = 2'd0; chipselect = 1'b0; write_n = 1'b1; writedata = '0; in_port = i;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

`ifndef KEY_IN_PIO_DEBOUNCE_EN
  // Reference model: the register view of a key is the input sampled two edges earlier;
  // an edge is a 1->0 step between consecutive visible values.
  logic [WIDTH-1:0] hist[$];
  logic [WIDTH-1:0] m_ec, m_mask;
  logic [31:0]      m_rd;

  task automatic model_reset();
    hist = '{4'h0, 4'h0, 4'h0};
    m_ec = '0; m_mask = '0; m_rd = '0;
  endtask

  task automatic model_edge(input logic [1:0] a, input logic c, input logic w,
                            input logic [31:0] d, input logic [WIDTH-1:0] i);
    logic [WIDTH-1:0] vis, vis_old, clr;
    vis     = hist[hist.size()-2];
    vis_old = hist[hist.size()-3];
    case (a)
      2'd0:    m_rd = 32'(vis);
      2'd2:    m_rd = 32'(m_mask);
      2'd3:    m_rd = 32'(m_ec);
      default: m_rd = 32'h0;
    endcase
    clr  = (c && !w && a == 2'd3) ? d[WIDTH-1:0] : '0;
    m_ec = (m_ec & ~clr) | (vis_old & ~vis);
    if (c && !w && a == 2'd2) m_mask = d[WIDTH-1:0];
    hist.push_back(i);
    if (hist.size() > 3) void'(hist.pop_front());
  endtask
`endif

  initial begin
    reset_n = 1'b0;
    address = 2'd0; chipselect = 1'b0; write_n = 1'b1; writedata = '0; in_port = 4'hF;
    repeat (2) @(negedge clk);
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    reset_n = 1'b1;

`ifndef KEY_IN_PIO_DEBOUNCE_EN
    //  addr  cs    wn    wdata          in     exp_rd   irq
    add(2'd0, 1'b0, 1'b1, 32'h0,         4'hF, 32'h0, 1'b0);
    add(2'd0, 1'b0, 1'b1, 32'h0,         4'hF, 32'h0, 1'b0);
    add(2'd0, 1'b0, 1'b1, 32'h0,         4'hF, 32'hF, 1'b0);
    add(2'd3, 1'b0, 1'b1, 32'h0,         4'hF, 32'h0, 1'b0);
    add(2'd1, 1'b1, 1'b0, 32'hFFFFFFFF,  4'hF, 32'h0, 1'b0);
    add(2'd0, 1'b1, 1'b0, 32'hFFFFFFFF,  4'hF, 32'hF, 1'b0);
    add(2'd1, 1'b1, 1'b1, 32'h0,         4'hF, 32'h0, 1'b0);
    add(2'd2, 1'b1, 1'b0, 32'h2,         4'hF, 32'h0, 1'b0);
    add(2'd2, 1'b1, 1'b1, 32'h0,         4'hF, 32'h2, 1'b0);
    add(2'd3, 1'b0, 1'b1, 32'h0,         4'hD, 32'h0, 1'b0);
    add(2'd3, 1'b0, 1'b1, 32'h0,         4'hD, 32'h0, 1'b0);
    add(2'd3, 1'b0, 1'b1, 32'h0,         4'hD, 32'h0, 1'b1);
    add(2'd3, 1'b0, 1'b1, 32'h0,         4'hD, 32'h2, 1'b1);
    add(2'd0, 1'b0, 1'b1, 32'h0,         4'hD, 32'hD, 1'b1);
    add(2'd3, 1'b1, 1'b0, 32'h2,         4'hD, 32'h2, 1'b0);
    add(2'd3, 1'b0, 1'b1, 32'h0,         4'hD, 32'h0, 1'b0);
    add(2'd2, 1'b1, 1'b0, 32'h0,         4'hD, 32'h2, 1'b0);
    add(2'd3, 1'b0, 1'b1, 32'h0,         4'hC, 32'h0, 1'b0);
    add(2'd3, 1'b0, 1'b1, 32'h0,         4'hC, 32'h0, 1'b0);
    add(2'd3, 1'b0, 1'b1, 32'h0,         4'hC, 32'h0, 1'b0);
    add(2'd3, 1'b0, 1'b1, 32'h0,         4'hC, 32'h1, 1'b0);
    add(2'd2, 1'b1, 1'b0, 32'h1,         4'hC, 32'h0, 1'b1);
    add(2'd2, 1'b0, 1'b1, 32'h0,         4'hC, 32'h1, 1'b1);
    add(2'd2, 1'b1, 1'b0, 32'h5,         4'hC, 32'h1, 1'b1);
    add(2'd3, 1'b0, 1'b1, 32'h0,         4'h8, 32'h1, 1'b1);
    add(2'd3, 1'b0, 1'b1, 32'h0,         4'h8, 32'h1, 1'b1);
    add(2'd3, 1'b0, 1'b1, 32'h0,         4'h8, 32'h1, 1'b1);
    add(2'd3, 1'b0, 1'b1, 32'h0,         4'h8, 32'h5, 1'b1);
    add(2'd3, 1'b0, 1'b1, 32'h0,         4'hC, 32'h5, 1'b1);
    add(2'd3, 1'b0, 1'b1, 32'h0,         4'hC, 32'h5, 1'b1);
    add(2'd3, 1'b0, 1'b1, 32'h0,         4'hC, 32'h5, 1'b1);
    add(2'd3, 1'b0, 1'b1, 32'h0,         4'h8, 32'h5, 1'b1);
    add(2'd3, 1'b0, 1'b1, 32'h0,         4'h8, 32'h5, 1'b1);
    add(2'd3, 1'b1, 1'b0, 32'h4,         4'h8, 32'h5, 1'b1);
    add(2'd3, 1'b0, 1'b1, 32'h0,         4'h8, 32'h5, 1'b1);
    add(2'd3, 1'b1, 1'b0, 32'hFFFFFFFF,  4'h8, 32'h5, 1'b0);
    add(2'd3, 1'b0, 1'b1, 32'h0,         4'h8, 32'h0, 1'b0);

    foreach (vecs[k]) begin
      step(vecs[k].addr, vecs[k].cs, vecs[k].wn, vecs[k].wd, vecs[k].inp);
      check($sformatf("vec%0d_readdata", k), readdata, vecs[k].exp_rd);
      check($sformatf("vec%0d_irq", k), 32'(irq), 32'(vecs[k].exp_irq));
    end

    // Mask is still 5: a bit2 fall raises irq, then an async reset drops it mid-cycle.
    step(2'd0, 1'b0, 1'b1, 32'h0, 4'hC);
    repeat (3) step(2'd0, 1'b0, 1'b1, 32'h0, 4'h8);
    step(2'd0, 1'b0, 1'b1, 32'h0, 4'h8);
    check("pre_async_reset_irq", 32'(irq), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_irq", 32'(irq), 32'h0);
    check("async_reset_readdata", readdata, 32'h0);

    // Randomized run against the reference model.
    begin
      logic [1:0]       a;
      logic             c, w;
      logic [31:0]      d;
      logic [WIDTH-1:0] i;
      int               rd_bad = 0;
      int               irq_bad = 0;
      i = WIDTH'($urandom);
      do_reset(i);
      model_reset();
      for (int n = 0; n < 3000; n++) begin
        if ($urandom_range(0, 3) == 0) i[$urandom_range(0, WIDTH-1)] ^= 1'b1;
        a = 2'($urandom_range(0, 3));
        c = 1'($urandom);
        w = ($urandom_range(0, 2) != 0);
        d = $urandom;
        model_edge(a, c, w, d, i);
        step(a, c, w, d, i);
        if (readdata !== m_rd && rd_bad < 5) begin
          rd_bad++;
          check($sformatf("rand%0d_readdata", n), readdata, m_rd);
        end else if (readdata === m_rd && n % 100 == 0) begin
          check($sformatf("rand%0d_readdata", n), readdata, m_rd);
        end
        if (irq !== (|(m_ec & m_mask)) && irq_bad < 5) begin
          irq_bad++;
          check($sformatf("rand%0d_irq", n), 32'(irq), 32'(|(m_ec & m_mask)));
        end else if (n % 100 == 50) begin
          check($sformatf("rand%0d_irq", n), 32'(irq), 32'(|(m_ec & m_mask)));
        end
      end
    end
`else
    begin
      int first = -1;
      int bad   = 0;
      for (int n = 0; n < 20 && first < 0; n++) begin
        step(2'd0, 1'b0, 1'b1, 32'h0, 4'hF);
        if (readdata == 32'hF) first = n;
      end
      check("db_settle_seen", 32'(first >= 0), 32'h1);
      step(2'd2, 1'b1, 1'b0, 32'h8, 4'hF);
      step(2'd3, 1'b1, 1'b0, 32'hF, 4'hF);

      repeat (5) step(2'd0, 1'b0, 1'b1, 32'h0, 4'h7);
      for (int n = 0; n < 20; n++) begin
        step(2'd0, 1'b0, 1'b1, 32'h0, 4'hF);
        if (readdata != 32'hF) bad++;
      end
      check("db_glitch_filt_changes", 32'(bad), 32'h0);
      step(2'd3, 1'b0, 1'b1, 32'h0, 4'hF);
      step(2'd3, 1'b0, 1'b1, 32'h0, 4'hF);
      check("db_glitch_edgecapture", readdata, 32'h0);
      check("db_glitch_irq", 32'(irq), 32'h0);

      first = -1;
      for (int n = 0; n < 12; n++) begin
        step(2'd0, 1'b0, 1'b1, 32'h0, 4'h7);
        if (readdata == 32'h7 && first < 0) first = n;
      end
      check("db_pulse_latency", 32'(first), 32'(DB + 2));
      step(2'd3, 1'b0, 1'b1, 32'h0, 4'hF);
      step(2'd3, 1'b0, 1'b1, 32'h0, 4'hF);
      check("db_pulse_edgecapture", readdata, 32'h8);
      check("db_pulse_irq", 32'(irq), 32'h1);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/soc_system_key_in_pio.md
# soc_system_key_in_pio

Avalon-MM slave input PIO: the read-side counterpart of the system's output PIOs (e.g. the hex-display drivers). It samples an external input bus (push-buttons / switches), synchronizes it, optionally debounces it, and latches selected edges into a write-1-to-clear edge-capture register. It raises a level interrupt to the HPS/Nios when an unmasked captured edge is pending. It sits on the lightweight HPS-to-FPGA bridge alongside the other PIO slaves.

## Interface
- WIDTH, 4: input bus width, 1..32
- CAPTURE_FALLING, 1: 1 = capture falling edges (active-low keys), 0 = capture rising edges
- DEBOUNCE_CYCLES, 50000: stability window in clk cycles, ≥2; used only with debounce compiled in

- clk  in  1  system clock
- reset_n  in  1  reset; asynchronous, active-low
- address  in  2  word address: 0 data, 1 direction, 2 interruptmask, 3 edgecapture
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data; bits [WIDTH-1:0] used
- in_port  in  WIDTH  asynchronous external inputs
- readdata  out  32  registered read data; bits above WIDTH always 0
- irq  out  1  level interrupt, high while (edgecapture & interruptmask) ≠ 0

## Operation
- Synchronizer: two flops, s1 <= in_port, s2 <= s1, all bits reset 0.
- Filtered value filt: equals s2 without debounce. With debounce, see Configuration. Reset 0.
- Edge detect: prev <= filt (reset 0). The edge vector is filt & ~prev (rising) or ~filt & prev (falling), chosen per CAPTURE_FALLING.
- edgecapture[i] sets on the clock after the edge for bit i is detected. It clears on a write to address 3 with writedata[i]=1. Writing 0 leaves the bit unchanged. If set and clear hit the same bit in the same cycle, set wins.
- interruptmask: read/write at address 2, bits [WIDTH-1:0], reset 0.
- Address 0 is read-only (returns filt). Address 1 is read-only 0, because the port is input-only. Writes to addresses 0 and 1 are ignored.
- A write occurs when chipselect && ~write_n.
- readdata <= zero-extended mux(address) every clock, independent of chipselect. Software-visible read latency is 1 cycle.
- irq = |(edgecapture & interruptmask), driven combinationally from registers; no glitches on input toggles.
- Reset mid-operation: all registers clear immediately and asynchronously; irq drops in the same instant.
- Post-reset artefact: with CAPTURE_FALLING=0, inputs that are already high produce one capture once synchronized. With CAPTURE_FALLING=1, inputs that are high cause no capture. Software clears edgecapture after enabling the mask. This behaviour is accepted.

## Timing
- All outputs reset to 0: readdata=0, irq=0.
- in_port change setup before edge E0:
  - s1 updates at E0, s2 at E1; filt equals s2 (no debounce).
  - The edge is detected combinationally after E1.
  - edgecapture is set at E2 and irq rises after E2.
  - Reading address 0 with the address held returns the new value in readdata after E2.
- Debounce adds DEBOUNCE_CYCLES cycles between s2 settling and filt changing.
- Mask write at edge Ew with a pending capture: irq rises after Ew.
- W1C at edge Ew: irq falls after Ew unless the same bit is re-set at Ew.
- Register read: address presented in cycle N, readdata valid in cycle N+1.

## Configuration
- Macro KEY_IN_PIO_DEBOUNCE_EN.
- Defined:
  - Each bit has a counter sized to $clog2(DEBOUNCE_CYCLES+1), reset 0.
  - When s2[i]==filt[i], the counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, filt[i] <= s2[i] and the counter clears.
  - Any bounce shorter than DEBOUNCE_CYCLES is rejected. There is no wrap-around: the counter never passes DEBOUNCE_CYCLES-1.
- Undefined: no counters are instantiated and filt = s2.

## Test plan
- Reset with in_port=4'hF, CAPTURE_FALLING=1 → readdata=0 and irq=0 during reset; address 0 reads 0x0000000F by cycle 3; edgecapture reads 0.
- Mask=4'b0010, in_port bit1 goes 1→0 → edgecapture=0x2 at E2; irq=1. Write 0x2 to address 3 → edgecapture=0 and irq=0 next cycle.
- Bit0 falling edge with mask=0 → edgecapture=0x1 and irq=0. Write mask=0x1 → irq=1 after that write edge.
- W1C of bit2 issued in the same cycle a new bit2 edge is detected → edgecapture[2] stays 1 and irq stays high.
- Debounce on, DEBOUNCE_CYCLES=8: a 5-cycle low glitch on bit3 → no filt change and no capture. A 12-cycle low pulse → filt[3]=0 after 8 stable cycles and edgecapture=0x8.
- Write 0xFFFFFFFF to address 1 and to address 0 → both have no effect; address 1 reads 0; upper readdata bits stay 0 for all addresses.
